// File: rtl/phase_accum_gen.sv
// phase_accum_gen: per-operator phase generator for the OPL3 operator pipeline.
// Converts fnum/block/mult/vibrato settings into a phase increment and
// accumulates it into a per-operator phase word held in an internal memory.
// After reset the memory is cleared one address per cycle before requests
// are accepted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sample_clk_en              one-cycle strobe per sample period (vibrato clock)
//   op_valid                   operator request strobe (accepted when ready=1)
//   bank_num, op_num           operator identity
//   fnum, block, mult          frequency number, octave, multiplier code
//   vib, dvb                   vibrato enable, deep vibrato select
//   key_on                     zero this operator's phase instead of advancing it
//   ready                      high when requests are accepted
//   out_valid                  result strobe, 3 cycles after the accepted request
//   out_bank, out_op           operator identity of the result
//   phase_inc                  increment used for this result
//   phase_out                  top PHASE_OUT_WIDTH bits of the updated accumulator
module phase_accum_gen #(
    parameter int unsigned NUM_BANKS       = 2,
    parameter int unsigned NUM_OPS         = 18,
    parameter int unsigned FNUM_WIDTH      = 10,
    parameter int unsigned BLOCK_WIDTH     = 3,
    parameter int unsigned PHASE_ACC_WIDTH = 20,
    parameter int unsigned PHASE_OUT_WIDTH = 10,
    parameter int unsigned VIB_STEP_LOG2   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_clk_en,
    input  logic                         op_valid,
    input  logic [$clog2(NUM_BANKS)-1:0] bank_num,
    input  logic [$clog2(NUM_OPS)-1:0]   op_num,
    input  logic [FNUM_WIDTH-1:0]        fnum,
    input  logic [BLOCK_WIDTH-1:0]       block,
    input  logic [3:0]                   mult,
    input  logic                         vib,
    input  logic                         dvb,
    input  logic                         key_on,
    output logic                         ready,
    output logic                         out_valid,
    output logic [$clog2(NUM_BANKS)-1:0] out_bank,
    output logic [$clog2(NUM_OPS)-1:0]   out_op,
    output logic [PHASE_ACC_WIDTH-1:0]   phase_inc,
    output logic [PHASE_OUT_WIDTH-1:0]   phase_out
);

    localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
    localparam int unsigned OP_W    = $clog2(NUM_OPS);
    localparam int unsigned DEPTH   = NUM_BANKS * NUM_OPS;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned VIB_W   = 3 + VIB_STEP_LOG2;
    localparam int unsigned FEFF_W  = FNUM_WIDTH + 1;
    localparam int unsigned SHIFT_W = FEFF_W + (1 << BLOCK_WIDTH) - 1;
    localparam int unsigned PROD_W  = SHIFT_W + 5;

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic              key_on;
    } tag_t;

    // Multiplier code to twice the multiplier (code 0 means x0.5).
    function automatic logic [4:0] mult_x2(input logic [3:0] m);
        logic [4:0] r;
        case (m)
            4'h0:        r = 5'd1;
            4'hA, 4'hB:  r = 5'd20;
            4'hC, 4'hD:  r = 5'd24;
            4'hE, 4'hF:  r = 5'd30;
            default:     r = {m, 1'b0};
        endcase
        return r;
    endfunction

    state_t               state;
    logic [ADDR_W-1:0]    clr_addr;
    logic [VIB_W-1:0]     vib_cnt;
    logic                 accept;
    logic [ADDR_W-1:0]    req_addr;

    logic                 p0_valid, p1_valid, p2_valid;
    tag_t                 p0_tag, p1_tag, p2_tag;
    logic [FNUM_WIDTH-1:0]  p0_fnum;
    logic [BLOCK_WIDTH-1:0] p0_block;
    logic [3:0]           p0_mult;
    logic                 p0_vib, p0_dvb;
    logic [2:0]           p0_pos;

    logic [FNUM_WIDTH-1:0] vib_d;
    logic [FNUM_WIDTH-1:0] vib_mag;
    logic [FEFF_W-1:0]     fnum_eff;

    logic [SHIFT_W-1:0]    p1_shifted;
    logic [4:0]            p1_mx2;
    logic [PROD_W-1:0]     prod;

    logic [PHASE_ACC_WIDTH-1:0] p2_inc, p2_acc, mem_rd, acc_new;
    logic [PHASE_ACC_WIDTH-1:0] mem [DEPTH];

    assign accept   = op_valid && ready;
    assign req_addr = ADDR_W'(bank_num) * ADDR_W'(NUM_OPS) + ADDR_W'(op_num);

    // Control FSM: sweep the phase memory to zero, then accept requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                RUN:     ready <= 1'b1;
                default: state <= CLEAR;
            endcase
        end
    end

    // Stage 1 vibrato: triangle offset on fnum; magnitude never exceeds fnum>>7,
    // so the subtraction cannot underflow.
    always_comb begin
        vib_d   = p0_dvb ? (p0_fnum >> 7) : (p0_fnum >> 8);
        vib_mag = '0;
        case (p0_pos[1:0])
            2'd1, 2'd3: vib_mag = vib_d >> 1;
            2'd2:       vib_mag = vib_d;
            default:    vib_mag = '0;
        endcase
        if (!p0_vib) begin
            vib_mag = '0;
        end
        fnum_eff = p0_pos[2] ? ({1'b0, p0_fnum} - {1'b0, vib_mag})
                             : ({1'b0, p0_fnum} + {1'b0, vib_mag});
    end

    assign prod    = PROD_W'(p1_shifted) * PROD_W'(p1_mx2);
    assign acc_new = p2_tag.key_on ? '0 : p2_acc + p2_inc;

    // Valid chain, vibrato counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vib_cnt   <= '0;
            p0_valid  <= 1'b0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_bank  <= '0;
            out_op    <= '0;
            phase_inc <= '0;
            phase_out <= '0;
        end else begin
            if (sample_clk_en) begin
                vib_cnt <= vib_cnt + VIB_W'(1);
            end
            p0_valid  <= accept;
            p1_valid  <= p0_valid;
            p2_valid  <= p1_valid;
            out_valid <= p2_valid;
            if (p2_valid) begin
                out_bank  <= p2_tag.bank;
                out_op    <= p2_tag.op;
                phase_inc <= p2_inc;
                phase_out <= acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
            end
        end
    end

    // Datapath registers; validity is tracked separately so these need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            p0_tag.bank   <= bank_num;
            p0_tag.op     <= op_num;
            p0_tag.addr   <= req_addr;
            p0_tag.key_on <= key_on;
            p0_fnum       <= fnum;
            p0_block      <= block;
            p0_mult       <= mult;
            p0_vib        <= vib;
            p0_dvb        <= dvb;
            p0_pos        <= vib_cnt[VIB_W-1 -: 3];
        end
        p1_tag     <= p0_tag;
        p1_shifted <= SHIFT_W'(fnum_eff) << p0_block;
        p1_mx2     <= mult_x2(p0_mult);
        p2_tag     <= p1_tag;
        p2_inc     <= PHASE_ACC_WIDTH'(prod >> 1);
        p2_acc     <= mem_rd;
    end

    // Phase memory: one read (stage 1) and one write (clear sweep or stage 3).
    always_ff @(posedge clk) begin
        mem_rd <= mem[p0_tag.addr];
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (p2_valid) begin
                mem[p2_tag.addr] <= acc_new;
            end
        end
    end

endmodule

// File: tb/tb_phase_accum_gen.sv
module tb_phase_accum_gen;

    localparam int NOPS = 18;
    localparam int NADDR = 36;

    logic        clk;
    logic        reset;
    logic        sample_clk_en;
    logic        op_valid;
    logic [0:0]  bank_num;
    logic [4:0]  op_num;
    logic [9:0]  fnum;
    logic [2:0]  block;
    logic [3:0]  mult;
    logic        vib;
    logic        dvb;
    logic        key_on;
    logic        ready;
    logic        out_valid;
    logic [0:0]  out_bank;
    logic [4:0]  out_op;
    logic [19:0] phase_inc;
    logic [9:0]  phase_out;

    phase_accum_gen dut (
        .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en),
        .op_valid(op_valid), .bank_num(bank_num), .op_num(op_num),
        .fnum(fnum), .block(block), .mult(mult), .vib(vib), .dvb(dvb),
        .key_on(key_on), .ready(ready), .out_valid(out_valid),
        .out_bank(out_bank), .out_op(out_op), .phase_inc(phase_inc),
        .phase_out(phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int bank;
        int op;
        int inc;
        int pout;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   acc_m [NADDR];
    int   last_req [NADDR];
    int   vib_m = 0;
    int   clr_m = 0;
    bit   ready_exp = 1'b0;
    bit   e_valid = 1'b0;
    int   e_bank = 0, e_op = 0, e_inc = 0, e_pout = 0;

    function automatic int mx2(input int m);
        int tbl [16];
        tbl = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
        return tbl[m];
    endfunction

    function automatic int model_inc(input int f, input int blk, input int m,
                                     input int v, input int deep, input int pos);
        int d;
        int mag;
        int fe;
        longint p;
        d   = deep ? f / 128 : f / 256;
        mag = (pos % 4 == 0) ? 0 : ((pos % 4 == 2) ? d : d / 2);
        fe  = f + (v ? ((pos >= 4) ? -mag : mag) : 0);
        p   = ((longint'(fe) << blk) * mx2(m)) / 2;
        return int'(p % (64'd1 << 20));
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int a;
        int inc;
        cyc++;
        if (reset) begin
            q.delete();
            for (int i = 0; i < NADDR; i++) begin
                acc_m[i] = 0;
                last_req[i] = -100;
            end
            vib_m = 0; clr_m = 0; ready_exp = 1'b0;
            e_valid = 1'b0; e_bank = 0; e_op = 0; e_inc = 0; e_pout = 0;
        end else begin
            e_valid = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                e_valid = 1'b1; e_bank = e.bank; e_op = e.op;
                e_inc = e.inc; e_pout = e.pout;
            end
            if (ready_exp && op_valid) begin
                a = int'(bank_num) * NOPS + int'(op_num);
                assert (cyc - last_req[a] >= 4)
                    else $error("address %0d re-requested within 4 cycles", a);
                last_req[a] = cyc;
                inc = model_inc(int'(fnum), int'(block), int'(mult), int'(vib),
                                int'(dvb), vib_m / 1024);
                acc_m[a] = key_on ? 0 : (acc_m[a] + inc) % (1 << 20);
                e.due = cyc + 3; e.bank = int'(bank_num); e.op = int'(op_num);
                e.inc = inc; e.pout = acc_m[a] / 1024;
                q.push_back(e);
            end
            if (!ready_exp) begin
                clr_m++;
                if (clr_m == NADDR) ready_exp = 1'b1;
            end
            if (sample_clk_en) vib_m = (vib_m + 1) % 8192;
        end
    end

    // Every cycle: outputs must match the model (including holding between results).
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("ready", ready, ready_exp);
            chk("out_valid", out_valid, e_valid);
            chk("out_bank", out_bank, e_bank);
            chk("out_op", out_op, e_op);
            chk("phase_inc", phase_inc, e_inc);
            chk("phase_out", phase_out, e_pout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, 36);
        @(negedge clk);
    endtask

    task automatic req(input int bk, input int op, input int f, input int blk,
                       input int m, input int v, input int deep, input int key,
                       input bit sce, input bit check, input int exp_inc,
                       input int exp_out, input string name);
        op_valid = 1'b1; bank_num = 1'(bk); op_num = 5'(op);
        fnum = 10'(f); block = 3'(blk); mult = 4'(m);
        vib = v[0]; dvb = deep[0]; key_on = key[0]; sample_clk_en = sce;
        @(negedge clk);
        op_valid = 1'b0; key_on = 1'b0; sample_clk_en = 1'b0;
        repeat (3) @(negedge clk);
        if (check) begin
            chk({name, " out_valid"}, out_valid, 1);
            chk({name, " phase_inc"}, phase_inc, exp_inc);
            chk({name, " phase_out"}, phase_out, exp_out);
        end
    endtask

    task automatic pulses(input int n);
        sample_clk_en = 1'b1;
        repeat (n) @(negedge clk);
        sample_clk_en = 1'b0;
    endtask

    initial begin
        int a;
        reset = 1'b1; sample_clk_en = 1'b0; op_valid = 1'b0;
        bank_num = '0; op_num = '0; fnum = '0; block = '0; mult = '0;
        vib = 1'b0; dvb = 1'b0; key_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", ready, 0);
        chk("reset out_valid", out_valid, 0);
        reset = 1'b0;
        wait_ready("ready delay after reset");

        // Cleared memory
        req(1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, "cleared");

        // Basic accumulation and mult codes
        req(0, 5, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h08, "acc1");
        req(0, 5, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h10, "acc2");
        req(0, 5, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h18, "acc3");
        req(0, 6, 'h200, 4, 0, 0, 0, 0, 0, 1, 'h1000, 'h04, "mult0");
        req(0, 8, 'h200, 4, 'hB, 0, 0, 0, 0, 1, 'h14000, 'h50, "multB");

        // Vibrato positions
        pulses(2048);
        req(0, 10, 'h380, 0, 1, 1, 1, 0, 0, 1, 'h387, 0, "vib pos2");
        req(0, 11, 'h380, 0, 1, 1, 0, 0, 0, 1, 'h383, 0, "vib pos2 shallow");
        pulses(4095);
        req(0, 13, 'h380, 0, 1, 1, 1, 0, 1, 1, 'h37D, 0, "vib coincident strobe");
        req(0, 14, 'h380, 0, 1, 1, 1, 0, 0, 1, 'h379, 0, "vib pos6");

        // Accumulator wrap and key-on
        for (int i = 0; i < 255; i++)
            req(1, 12, 'h200, 4, 0, 0, 0, 0, 0, 0, 0, 0, "");
        req(1, 12, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h004, "wrap");
        req(1, 12, 'h200, 4, 1, 0, 0, 1, 0, 1, 'h2000, 'h000, "key_on");
        req(1, 12, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h008, "after key_on");

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            sample_clk_en = ($urandom % 4 == 0);
            a = int'($urandom % NADDR);
            if (($urandom % 2 == 0) && (cyc + 1 - last_req[a] >= 4)) begin
                op_valid = 1'b1; bank_num = 1'(a / NOPS); op_num = 5'(a % NOPS);
                fnum = 10'($urandom); block = 3'($urandom); mult = 4'($urandom);
                vib = 1'($urandom); dvb = 1'($urandom);
                key_on = ($urandom % 16 == 0);
            end else begin
                op_valid = 1'b0; key_on = 1'b0;
            end
            @(negedge clk);
        end
        op_valid = 1'b0; sample_clk_en = 1'b0; key_on = 1'b0;
        repeat (4) @(negedge clk);

        // Back-to-back stream interrupted by reset
        for (int i = 0; i < NADDR; i++) begin
            op_valid = 1'b1; bank_num = 1'(i / NOPS); op_num = 5'(i % NOPS);
            fnum = 10'($urandom); block = 3'($urandom); mult = 4'($urandom);
            vib = 1'b0; key_on = 1'b0;
            if (i == 20) reset = 1'b1;
            @(negedge clk);
            if (i == 20) break;
        end
        chk("out_valid drop on reset", out_valid, 0);
        op_valid = 1'b0;
        reset = 1'b0;
        wait_ready("ready delay after mid-stream reset");
        req(1, 3, 'h200, 4, 1, 0, 0, 0, 0, 1, 'h2000, 'h08, "restart");
        for (int i = 0; i < NADDR; i++) begin
            op_valid = 1'b1; bank_num = 1'(i / NOPS); op_num = 5'(i % NOPS);
            fnum = 10'h200; block = 3'd4; mult = 4'd1; vib = 1'b0; key_on = 1'b0;
            @(negedge clk);
        end
        op_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_accum_gen.md
# phase_accum_gen

Per-operator phase generator for the OPL3 operator pipeline. It turns each operator's fnum/block/mult/vibrato settings into a phase increment, with vibrato applied to fnum before the block shift. It then accumulates that increment into a per-operator phase register held in internal memory and emits the truncated phase for the waveform lookup stage. It is parametrised in operator count, bank count and widths, and adds key-on phase reset, an internal vibrato position counter and a post-reset memory clear sequence.

## Interface
- NUM_BANKS, 2, number of register banks
- NUM_OPS, 18, operators per bank
- FNUM_WIDTH, 10, fnum width
- BLOCK_WIDTH, 3, block (octave) width
- PHASE_ACC_WIDTH, 20, accumulator width
- PHASE_OUT_WIDTH, 10, emitted phase width (MSBs of accumulator)
- VIB_STEP_LOG2, 10, log2 of sample periods per vibrato position

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sample_clk_en  in  1  one-cycle strobe per sample period; advances vibrato counter
- op_valid  in  1  operator request strobe
- bank_num  in  $clog2(NUM_BANKS)  operator bank
- op_num  in  $clog2(NUM_OPS)  operator index
- fnum  in  FNUM_WIDTH  frequency number
- block  in  BLOCK_WIDTH  octave shift
- mult  in  4  multiplier register code
- vib  in  1  vibrato enable
- dvb  in  1  deep vibrato select
- key_on  in  1  with op_valid: reset this operator's phase
- ready  out  1  high when requests are accepted
- out_valid  out  1  result strobe
- out_bank, out_op  out  as inputs  operator identity of result
- phase_inc  out  PHASE_ACC_WIDTH  increment used for this result
- phase_out  out  PHASE_OUT_WIDTH  accumulator[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] after update

## Operation
- States: CLEAR, RUN. Reset enters CLEAR.
- CLEAR: write 0 to addresses 0..NUM_BANKS*NUM_OPS-1, one per cycle, then enter RUN. ready=0 throughout; op_valid is ignored.
- RUN: ready=1. The address is bank_num*NUM_OPS+op_num.
- Vibrato counter: 3+VIB_STEP_LOG2 bits, free-running, +1 per sample_clk_en, wraps. pos = top 3 bits.
- Vibrato offset:
  - d = fnum>>7, then >>1 more when dvb=0.
  - pos 0,4 → 0; pos 1,5 → d>>1; pos 2,6 → d; pos 3,7 → d>>1.
  - Sign is negative for pos 4..7. Offset is 0 when vib=0.
- fnum_eff = fnum + offset; FNUM_WIDTH+1 bits; cannot go negative.
- mult map ×2: 0→1, 1→2, 2→4, 3→6, 4→8, 5→10, 6→12, 7→14, 8→16, 9→18, A/B→20, C/D→24, E/F→30.
- phase_inc = ((fnum_eff<<block) * mult_x2) >> 1, truncated to PHASE_ACC_WIDTH.
- Accumulator: acc_new = key_on ? 0 : (acc + phase_inc) mod 2^PHASE_ACC_WIDTH. acc_new is written back and drives phase_out.
- Each operator is requested at most once per sample period. The same address must not be re-requested within 4 cycles; the bench asserts this and the block has no forwarding.

## Timing
- Pipeline: p0 request registered; p1 offset, shift, mult lookup, memory read issued; p2 multiply, read data valid; p3 add/write, outputs registered.
- Latency: out_valid exactly 3 cycles after the accepted op_valid. Full throughput is one request per cycle.
- Outputs change only with out_valid; they hold their values otherwise.
- Reset values:
  - ready=0, out_valid=0; phase_out, phase_inc, out_bank, out_op = 0
  - vibrato counter = 0
- Reset mid-operation: in-flight requests are dropped and out_valid=0 from the next cycle. CLEAR restarts at address 0.
- ready rises NUM_BANKS*NUM_OPS cycles after reset deasserts (36 at defaults).
- sample_clk_en coinciding with op_valid: that request uses the pre-increment pos.
- Wrap: accumulator overflow is modulo 2^PHASE_ACC_WIDTH, with no saturation.

## Test plan
- Reset release → ready low for exactly 36 cycles. Then any operator with fnum=0, key_on=0 → phase_out=0, proving memory was cleared.
- op 5 bank 0, fnum=0x200, block=4, mult=1, vib=0, repeated once per sample → phase_inc=0x2000; phase_out 0x08, 0x10, 0x18; out_valid 3 cycles after each request.
- Same settings with mult=0 → phase_inc=0x1000; with mult=0xB → 0x14000.
- fnum=0x380, block=0, mult=1, vib=1, dvb=1:
  - after 2048 sample_clk_en (pos 2) → phase_inc=0x387
  - after 6144 (pos 6) → 0x379
  - dvb=0 at pos 2 → 0x383
- Accumulator at 0xFF000, phase_inc 0x2000 → wraps to 0x01000, phase_out=0x004. Next request with key_on=1 → phase_out=0, and the following increment restarts from 0.
- Back-to-back requests for 36 distinct operators, with reset asserted mid-stream → out_valid drops the next cycle, ready stays low 36 cycles, and all phases restart from 0.
